// File: rtl/program_sequencer_if.sv
// program_sequencer_if: bundles the load/run/step controls, the datapath
// handshake and the status outputs of program_sequencer.
// master = stimulus / host side, slave = the sequencer itself.
interface program_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          LOAD;
  logic [9:0]    IN_DATA;
  logic          RUN;
  logic          MODE_STEP;
  logic          ADV;
  logic          DP_DONE;
  logic [9:0]    INSTR_OUT;
  logic          ISSUE;
  logic [PW-1:0] PC;
  logic [CW-1:0] COUNT;
  logic          BUSY;
  logic          FULL;
  logic          HALT;
  logic          ERR;

  modport master (
    output LOAD, IN_DATA, RUN, MODE_STEP, ADV, DP_DONE,
    input  INSTR_OUT, ISSUE, PC, COUNT, BUSY, FULL, HALT, ERR
  );

  modport slave (
    input  LOAD, IN_DATA, RUN, MODE_STEP, ADV, DP_DONE,
    output INSTR_OUT, ISSUE, PC, COUNT, BUSY, FULL, HALT, ERR
  );
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: small instruction buffer plus an issue FSM that hands
// one 10-bit word at a time to a datapath and waits for DP_DONE.
// Optional feature macro: SEQ_WATCHDOG_EN -- when defined, a 4-bit counter
// aborts to DONE with ERR set after 16 WAIT cycles without DP_DONE.
// Reset (CLR) is synchronous, active-high; the buffer itself is never reset.
module program_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic                 CLKb,
  input  logic                 CLR,
  program_sequencer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          issue_q, issue_d;
  logic          busy_q, busy_d;
  logic          halt_q, halt_d;
`ifdef SEQ_WATCHDOG_EN
  logic [3:0]    wd_q, wd_d;
`endif

  logic [9:0]    mem_q [DEPTH];
  logic          wr_en_s;
  logic [PW-1:0] wr_addr_s;
  logic [9:0]    wr_data_s;
  logic          full_s;
  logic          last_s;

  assign full_s = (count_q == CW'(DEPTH));
  // PC points at the final loaded word
  assign last_s = ({1'b0, pc_q} == (count_q - CW'(1)));

  // Next-state, buffer write and registered-output decode
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_s   = 1'b0;
    wr_addr_s = count_q[PW-1:0];
    wr_data_s = bus.IN_DATA;
`ifdef SEQ_WATCHDOG_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.RUN) begin
          if (count_q != {CW{1'b0}}) begin
            state_d = S_ISSUE;
            pc_d    = {PW{1'b0}};
            // a LOAD arriving with an accepted RUN is dropped and flagged
            err_d   = bus.LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end else if (bus.LOAD) begin
          if (full_s) begin
            err_d   = 1'b1;
          end else begin
            wr_en_s = 1'b1;
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef SEQ_WATCHDOG_EN
        wd_d    = 4'd0;
`endif
        if (bus.LOAD) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end
      S_WAIT: begin
        if (bus.LOAD) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bus.DP_DONE) begin
          if (last_s) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PW'(1);
            // step mode is decided here, at completion time only
            state_d = bus.MODE_STEP ? S_PAUSE : S_ISSUE;
          end
        end else begin
`ifdef SEQ_WATCHDOG_EN
          if (wd_q == 4'hF) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            wd_d    = wd_q + 4'd1;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_PAUSE: begin
        if (bus.LOAD) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bus.ADV) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        if (bus.RUN) begin
          state_d = S_ISSUE;
          pc_d    = {PW{1'b0}};
          err_d   = 1'b0;
        end else if (bus.LOAD) begin
          // start a fresh program: the new word becomes entry 0
          state_d   = S_IDLE;
          count_d   = CW'(1);
          wr_en_s   = 1'b1;
          wr_addr_s = {PW{1'b0}};
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = {PW{1'b0}};
        count_d = {CW{1'b0}};
      end
    endcase

    issue_d = (state_d == S_ISSUE);
    busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_PAUSE);
    halt_d  = (state_d == S_DONE);
  end

  // FSM, counters and status flags; CLR overrides every input
  always_ff @(posedge CLKb) begin
    if (CLR) begin
      state_q <= S_IDLE;
      pc_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      err_q   <= 1'b0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      issue_q <= issue_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
`ifdef SEQ_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // Instruction buffer write port; contents survive CLR
  always_ff @(posedge CLKb) begin
    if (wr_en_s && !CLR) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign bus.INSTR_OUT = mem_q[pc_q];
  assign bus.ISSUE     = issue_q;
  assign bus.PC        = pc_q;
  assign bus.COUNT     = count_q;
  assign bus.BUSY      = busy_q;
  assign bus.FULL      = full_s;
  assign bus.HALT      = halt_q;
  assign bus.ERR       = err_q;
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter: DEPTH, 8, instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have port: CLKb, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port: CLR, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: LOAD, input, 1, write IN_DATA into the next free buffer entry.
REQ-005 SHALL have port: IN_DATA, input, 10, instruction word to load.
REQ-006 SHALL have port: RUN, input, 1, start execution from entry 0.
REQ-007 SHALL have port: MODE_STEP, input, 1, 1 = pause after each instruction.
REQ-008 SHALL have port: ADV, input, 1, advance from pause (single-step).
REQ-009 SHALL have port: DP_DONE, input, 1, datapath reports current instruction finished.
REQ-010 SHALL have port: INSTR_OUT, output, 10, instruction presented to datapath = buf[PC].
REQ-011 SHALL have port: ISSUE, output, 1, one-cycle pulse telling datapath to latch INSTR_OUT.
REQ-012 SHALL have port: PC, output, clog2(DEPTH), index of current instruction.
REQ-013 SHALL have port: COUNT, output, clog2(DEPTH)+1, number of loaded words.
REQ-014 SHALL have ports: BUSY, FULL, HALT, ERR, output, 1 each, status flags.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, PAUSE, DONE; BUSY=1 in ISSUE/WAIT/PAUSE, HALT=1 only in DONE.
REQ-016 IDLE: RUN with COUNT>0 -> PC=0, ERR=0, go ISSUE next cycle; RUN with COUNT=0 -> set ERR, stay IDLE.
REQ-017 IDLE: LOAD with COUNT<DEPTH -> buf[COUNT]=IN_DATA, COUNT+1; LOAD with COUNT=DEPTH -> no write, set ERR.
REQ-018 IDLE, LOAD and RUN same cycle: RUN wins, LOAD dropped, ERR set (overrides the ERR clear of REQ-016).
REQ-019 ISSUE: ISSUE=1 exactly this cycle, INSTR_OUT=buf[PC]; unconditional -> WAIT.
REQ-020 WAIT: DP_DONE=1 and PC=COUNT-1 -> DONE; DP_DONE=1 otherwise -> PC+1, then PAUSE if MODE_STEP=1 else ISSUE; DP_DONE=0 -> stay.
REQ-021 DP_DONE SHALL be ignored in every state except WAIT; minimum issue-to-done latency is 1 cycle.
REQ-022 PAUSE: ADV=1 -> ISSUE; MODE_STEP sampled on DP_DONE only (changing it during PAUSE has no effect until next DP_DONE).
REQ-023 DONE: RUN -> PC=0, ERR=0, ISSUE (rerun same program); LOAD -> COUNT=1, buf[0]=IN_DATA, go IDLE (new program); RUN wins if both.
REQ-024 LOAD or RUN while BUSY SHALL be ignored; LOAD while BUSY sets ERR, RUN while BUSY does not.
REQ-025 FULL = (COUNT=DEPTH) combinationally from registered COUNT; ERR sticky until CLR or accepted RUN.
REQ-026 INSTR_OUT SHALL hold buf[PC] in all states; back-to-back issue throughput is one instruction per 2 cycles + datapath latency.

Reset
REQ-027 CLR=1 at a rising edge SHALL force: state IDLE, PC=0, COUNT=0, ISSUE=0, BUSY=0, HALT=0, ERR=0; takes priority over all inputs, including mid-execution.
REQ-028 Buffer contents SHALL NOT be reset; INSTR_OUT after reset reflects buf[0] and is don't-care until loaded.

Configuration
REQ-029 Macro SEQ_WATCHDOG_EN defined: 4-bit counter cleared on entering WAIT; 16 consecutive WAIT cycles without DP_DONE -> set ERR, go DONE, PC unchanged.
REQ-030 SEQ_WATCHDOG_EN undefined: no counter, WAIT holds indefinitely; all other behaviour identical.

Verification
REQ-031 CLR, LOAD 0x101,0x202,0x303, RUN, DP_DONE 2 cycles after each ISSUE -> ISSUE pulses with INSTR_OUT 0x101,0x202,0x303, PC 0,1,2, then HALT=1, COUNT=3.
REQ-032 LOAD 9 words with DEPTH=8 -> FULL=1 after 8th, 9th not written, ERR=1, COUNT=8; RUN with COUNT=0 after CLR -> ERR=1, state IDLE.
REQ-033 MODE_STEP=1, 2-word program -> after first DP_DONE sequencer sits in PAUSE with PC=1, no ISSUE until ADV pulse, then ISSUE with buf[1].
REQ-034 CLR asserted in WAIT at PC=2 -> next cycle IDLE, PC=0, COUNT=0, BUSY=0; DP_DONE pulse in IDLE/ISSUE -> no state change.
REQ-035 With SEQ_WATCHDOG_EN, withhold DP_DONE 16 cycles -> ERR=1, HALT=1; without macro, same stimulus -> still BUSY after 100 cycles.
REQ-036 In DONE, LOAD 0x3FF -> IDLE, COUNT=1; simultaneous LOAD+RUN in IDLE -> execution starts, COUNT unchanged, ERR=1.
